// File: rtl/sseg_pkg.sv
// Shared field layout and helpers for the multiplexed 7-segment scan controller.
package sseg_pkg;
  localparam int EN_BIT  = 5;
  localparam int HEX_MSB = 4;
  localparam int HEX_LSB = 1;
  localparam int DP_BIT  = 0;
  localparam int DIGIT_W = 6;

  localparam logic [6:0] SSEG_BLANK = 7'h7F;

  typedef logic [DIGIT_W-1:0] digit_t;

  function automatic int dig_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/hex2sseg.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex2sseg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/sseg_scan_timer.sv
// Scan timing: prescaler -> PWM sub-tick counter -> digit index, plus frame boundary strobe.
module sseg_scan_timer import sseg_pkg::*; #(
  parameter  int N_DIGITS = 8,
  parameter  int SUB_DIV  = 781,
  parameter  int BRIGHT_W = 4,
  localparam int DIG_W    = dig_w(N_DIGITS)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                sub_tick,
  output logic [BRIGHT_W-1:0] pwm_cnt,
  output logic [DIG_W-1:0]    dig_idx,
  output logic                frame_boundary
);
  localparam int PRESC_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;

  logic [PRESC_W-1:0] presc;
  logic               pwm_wrap;
  logic               last_dig;

  assign sub_tick       = (presc == PRESC_W'(SUB_DIV - 1));
  assign pwm_wrap       = &pwm_cnt;
  assign last_dig       = (dig_idx == DIG_W'(N_DIGITS - 1));
  assign frame_boundary = sub_tick && pwm_wrap && last_dig;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      pwm_cnt <= '0;
      dig_idx <= '0;
    end else if (sub_tick) begin
      presc   <= '0;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_wrap)
        dig_idx <= last_dig ? '0 : dig_idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end
endmodule

// File: rtl/sseg_scan_ctrl.sv
// Double-buffered multiplexed 7-segment scan controller with PWM brightness.
// Optional per-digit blinking is compiled in with SSEG_BLINK_EN.
module sseg_scan_ctrl import sseg_pkg::*; #(
  parameter  int N_DIGITS     = 8,
  parameter  int SUB_DIV      = 781,
  parameter  int BRIGHT_W     = 4,
`ifdef SSEG_BLINK_EN
  parameter  int BLINK_FRAMES = 32,
`endif
  localparam int DIG_W        = dig_w(N_DIGITS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [DIG_W-1:0]    wr_addr,
  input  logic [5:0]          wr_data,
  input  logic                commit,
  input  logic [BRIGHT_W-1:0] brightness,
`ifdef SSEG_BLINK_EN
  input  logic [N_DIGITS-1:0] blink_mask,
`endif
  output logic [N_DIGITS-1:0] AN,
  output logic [6:0]          sseg,
  output logic                DP,
  output logic                frame_done,
  output logic                busy
);
  logic                sub_tick, frame_boundary, boundary;
  logic [BRIGHT_W-1:0] pwm_cnt;
  logic [DIG_W-1:0]    dig_idx;

  digit_t [N_DIGITS-1:0] shadow, display;
  digit_t                cur;
  logic                  pending, lit, dp_nxt;
  logic [N_DIGITS-1:0]   an_nxt;
  logic [6:0]            seg_dec, sseg_nxt;

  sseg_scan_timer #(.N_DIGITS(N_DIGITS), .SUB_DIV(SUB_DIV), .BRIGHT_W(BRIGHT_W)) u_timer (
    .clk(clk), .reset(reset), .sub_tick(sub_tick), .pwm_cnt(pwm_cnt),
    .dig_idx(dig_idx), .frame_boundary(frame_boundary)
  );

  // frame_boundary already implies sub_tick; the AND keeps the qualifier explicit here.
  assign boundary = sub_tick && frame_boundary;
  assign cur      = display[dig_idx];
  assign busy     = pending;

  hex2sseg u_dec (.hex(cur[HEX_MSB:HEX_LSB]), .seg(seg_dec));

`ifdef SSEG_BLINK_EN
  localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BCNT_W-1:0] blink_cnt;
  logic              blink_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (boundary) begin
      if (blink_cnt == BCNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`endif

  // Max brightness still leaves one dark sub-tick per slot, so adjacent digits never ghost.
  always_comb begin
    lit = cur[EN_BIT] && (pwm_cnt < brightness);
`ifdef SSEG_BLINK_EN
    if (blink_phase && blink_mask[dig_idx]) lit = 1'b0;
`endif
    an_nxt   = '1;
    sseg_nxt = SSEG_BLANK;
    dp_nxt   = 1'b1;
    if (lit) begin
      an_nxt[dig_idx] = 1'b0;
      sseg_nxt        = seg_dec;
      dp_nxt          = ~cur[DP_BIT];
    end
  end

  // The copy takes the shadow value from before this cycle's write, so a write
  // colliding with the copy only becomes visible after the following commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow     <= '0;
      display    <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      AN         <= '1;
      sseg       <= SSEG_BLANK;
      DP         <= 1'b1;
    end else begin
      if (wr_en && (32'(wr_addr) < N_DIGITS))
        shadow[wr_addr] <= wr_data;
      if (boundary) begin
        if (pending || commit) display <= shadow;
        pending <= 1'b0;
      end else if (commit) begin
        pending <= 1'b1;
      end
      frame_done <= boundary;
      AN         <= an_nxt;
      sseg       <= sseg_nxt;
      DP         <= dp_nxt;
    end
  end
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Randomized bench for sseg_scan_ctrl against a time-indexed reference model (4 digits, 32-cycle frame).
module tb_sseg_scan_ctrl;
  localparam int N     = 4;
  localparam int SD    = 2;
  localparam int BW    = 2;
  localparam int SLOT  = SD * (1 << BW);
  localparam int FRAME = N * SLOT;

  logic       clk = 1'b0;
  logic       reset, wr_en, commit;
  logic [1:0] wr_addr, brightness;
  logic [5:0] wr_data;
  logic [3:0] AN;
  logic [6:0] sseg;
  logic       DP, frame_done, busy;
`ifdef SSEG_BLINK_EN
  logic [3:0] blink_mask = 4'b0000;
`endif

  always #5 clk = ~clk;

`ifdef SSEG_BLINK_EN
  sseg_scan_ctrl #(.N_DIGITS(N), .SUB_DIV(SD), .BRIGHT_W(BW), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .brightness(brightness), .blink_mask(blink_mask), .AN(AN),
    .sseg(sseg), .DP(DP), .frame_done(frame_done), .busy(busy));
`else
  sseg_scan_ctrl #(.N_DIGITS(N), .SUB_DIV(SD), .BRIGHT_W(BW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .brightness(brightness), .AN(AN),
    .sseg(sseg), .DP(DP), .frame_done(frame_done), .busy(busy));
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: t = cycles of scan time since reset release.
  logic [5:0] m_shadow [N];
  logic [5:0] m_disp   [N];
  bit         m_pend;
  int         t;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp, exp_fd, exp_busy;

  function automatic logic [6:0] seg_ref(input logic [3:0] h);
    logic [6:0] on;
    case (h)
      4'h0: on = 7'h3F; 4'h1: on = 7'h06; 4'h2: on = 7'h5B; 4'h3: on = 7'h4F;
      4'h4: on = 7'h66; 4'h5: on = 7'h6D; 4'h6: on = 7'h7D; 4'h7: on = 7'h07;
      4'h8: on = 7'h7F; 4'h9: on = 7'h6F; 4'hA: on = 7'h77; 4'hB: on = 7'h7C;
      4'hC: on = 7'h39; 4'hD: on = 7'h5E; 4'hE: on = 7'h79; default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  function automatic logic [13:0] got();
    return {AN, sseg, DP, frame_done, busy};
  endfunction

  function automatic logic [13:0] expv();
    return {exp_an, exp_seg, exp_dp, exp_fd, exp_busy};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_shadow[i] = '0; m_disp[i] = '0; end
    m_pend = 0;
    t = 0;
  endtask

  task automatic idle();
    wr_en = 0; commit = 0; wr_addr = '0; wr_data = '0;
  endtask

  // Predict the outputs produced by this edge, update the model, then clock.
  task automatic tick();
    int dig, pwm;
    bit lit, bnd;
    logic [5:0] e;
    dig = (t / SLOT) % N;
    pwm = (t / SD) % (1 << BW);
    e   = m_disp[dig];
    lit = e[5] && (pwm < int'(brightness));
`ifdef SSEG_BLINK_EN
    if (((t / FRAME) / 2) % 2 == 1 && blink_mask[dig]) lit = 0;
`endif
    exp_an  = lit ? ~(4'b0001 << dig) : 4'hF;
    exp_seg = lit ? seg_ref(e[4:1]) : 7'h7F;
    exp_dp  = lit ? ~e[0] : 1'b1;
    bnd = (t % FRAME == FRAME - 1);
    if (bnd) begin
      if (m_pend || commit) for (int i = 0; i < N; i++) m_disp[i] = m_shadow[i];
      m_pend = 0;
    end else if (commit) begin
      m_pend = 1;
    end
    if (wr_en) m_shadow[wr_addr] = wr_data;
    exp_fd   = bnd;
    exp_busy = m_pend;
    @(posedge clk); #1;
    t++;
  endtask

  task automatic test_reset();
    int fd_cnt = 0;
    idle(); brightness = 2'd3; reset = 1;
    @(posedge clk); #1; @(posedge clk); #1;
    n_tests++;
    if (got() !== {4'hF, 7'h7F, 3'b100}) begin
      n_fail++; $display("FAIL reset_vals got=%h exp=%h", got(), {4'hF, 7'h7F, 3'b100});
    end
    model_reset(); reset = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      brightness = 2'($urandom);
      tick();
      n_tests++;
      if (got() !== expv()) begin n_fail++; $display("FAIL reset_idle t=%0d got=%h exp=%h", t, got(), expv()); end
      if (frame_done) fd_cnt++;
      if (AN !== 4'hF) begin n_tests++; n_fail++; $display("FAIL idle_dark t=%0d AN=%h exp=f", t, AN); end
    end
    n_tests++;
    if (fd_cnt != 2) begin n_fail++; $display("FAIL frame_period pulses=%0d exp=2", fd_cnt); end
  endtask

  task automatic test_display();
    int cnt [N];
    for (int a = 0; a < N; a++) begin
      wr_en = 1; wr_addr = 2'(a); wr_data = {1'b1, 4'(a + 1), a[0]};
      tick();
      n_tests++;
      if (got() !== expv()) begin n_fail++; $display("FAIL disp_wr t=%0d got=%h exp=%h", t, got(), expv()); end
    end
    idle(); commit = 1; brightness = 2'd3;
    tick(); commit = 0;
    for (int i = 0; i < FRAME + 1; i++) begin
      tick();
      n_tests++;
      if (got() !== expv()) begin n_fail++; $display("FAIL disp_wait t=%0d got=%h exp=%h", t, got(), expv()); end
      if (exp_fd) break;
    end
    for (int k = 0; k < N; k++) cnt[k] = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      n_tests++;
      if (got() !== expv()) begin n_fail++; $display("FAIL disp_frame t=%0d got=%h exp=%h", t, got(), expv()); end
      for (int k = 0; k < N; k++) if (AN[k] === 1'b0) cnt[k]++;
    end
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (cnt[k] != 6) begin n_fail++; $display("FAIL duty_b3 digit=%0d on=%0d exp=6", k, cnt[k]); end
    end
  endtask

  task automatic test_brightness();
    int cnt [N];
    brightness = 2'd0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      n_tests++;
      if (AN !== 4'hF || got() !== expv()) begin n_fail++; $display("FAIL bright0 t=%0d got=%h exp=%h", t, got(), expv()); end
    end
    brightness = 2'd1;
    while (t % FRAME != 0) begin
      tick();
      n_tests++;
      if (got() !== expv()) begin n_fail++; $display("FAIL bright_align t=%0d got=%h exp=%h", t, got(), expv()); end
    end
    tick();
    for (int k = 0; k < N; k++) cnt[k] = 0;
    for (int i = 0; i < FRAME; i++) begin
      for (int k = 0; k < N; k++) if (AN[k] === 1'b0) cnt[k]++;
      tick();
    end
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (cnt[k] != 2) begin n_fail++; $display("FAIL duty_b1 digit=%0d on=%0d exp=2", k, cnt[k]); end
    end
  endtask

  task automatic test_shadow();
    brightness = 2'd3;
    wr_en = 1; wr_addr = 2'd2; wr_data = {1'b1, 4'hA, 1'b0};
    tick(); idle();
    for (int i = 0; i < FRAME; i++) begin
      tick();
      n_tests++;
      if (got() !== expv() || (AN === 4'b1011 && sseg !== seg_ref(4'h3))) begin
        n_fail++; $display("FAIL shadow_hidden t=%0d got=%h exp=%h", t, got(), expv());
      end
    end
    while (t % FRAME != 10) tick();
    commit = 1; tick(); commit = 0;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_set busy=%b exp=1", busy); end
    for (int i = 0; i < FRAME + 1; i++) begin
      tick();
      n_tests++;
      if (got() !== expv()) begin n_fail++; $display("FAIL commit_wait t=%0d got=%h exp=%h", t, got(), expv()); end
      if (exp_fd) break;
    end
    n_tests++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_drop fd=%b busy=%b exp fd=1 busy=0", frame_done, busy);
    end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      n_tests++;
      if (got() !== expv() || (AN === 4'b1011 && sseg !== seg_ref(4'hA))) begin
        n_fail++; $display("FAIL shadow_shown t=%0d got=%h exp=%h", t, got(), expv());
      end
    end
  endtask

  task automatic test_wr_copy();
    brightness = 2'd3;
    commit = 1; tick(); commit = 0;
    while (t % FRAME != FRAME - 1) tick();
    wr_en = 1; wr_addr = 2'd1; wr_data = {1'b1, 4'h7, 1'b1};
    tick(); idle();
    for (int i = 0; i < FRAME; i++) begin
      tick();
      n_tests++;
      if (got() !== expv() || (AN === 4'b1101 && sseg !== seg_ref(4'h2))) begin
        n_fail++; $display("FAIL wr_copy_old t=%0d got=%h exp=%h", t, got(), expv());
      end
    end
    commit = 1; tick(); commit = 0;
    for (int i = 0; i < FRAME + 1; i++) begin tick(); if (exp_fd) break; end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      n_tests++;
      if (got() !== expv() || (AN === 4'b1101 && sseg !== seg_ref(4'h7))) begin
        n_fail++; $display("FAIL wr_copy_new t=%0d got=%h exp=%h", t, got(), expv());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8 * FRAME; i++) begin
      wr_en      = ($urandom_range(3) == 0);
      wr_addr    = 2'($urandom);
      wr_data    = 6'($urandom);
      commit     = ($urandom_range(15) == 0);
      brightness = 2'($urandom);
      tick();
      n_tests++;
      if (got() !== expv()) begin n_fail++; $display("FAIL random t=%0d got=%h exp=%h", t, got(), expv()); end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    brightness = 2'd3;
    while (t % SLOT != 3) tick();
    reset = 1;
    @(posedge clk); #1;
    n_tests++;
    if (got() !== {4'hF, 7'h7F, 3'b100}) begin
      n_fail++; $display("FAIL reset_mid got=%h exp=%h", got(), {4'hF, 7'h7F, 3'b100});
    end
    reset = 0; model_reset();
    commit = 1; tick(); commit = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      n_tests++;
      if (AN !== 4'hF || got() !== expv()) begin n_fail++; $display("FAIL banks_cleared t=%0d got=%h exp=%h", t, got(), expv()); end
    end
  endtask

`ifdef SSEG_BLINK_EN
  task automatic test_blink();
    int cnt [6];
    idle(); reset = 1; @(posedge clk); #1; reset = 0; model_reset();
    brightness = 2'd3; blink_mask = 4'b0001;
    for (int f = 0; f < 6; f++) cnt[f] = 0;
    for (int a = 0; a < N; a++) begin
      wr_en = 1; wr_addr = 2'(a); wr_data = {1'b1, 4'(a + 1), 1'b0}; tick();
    end
    idle(); commit = 1; tick(); commit = 0;
    while (t < 6 * FRAME) begin
      tick();
      n_tests++;
      if (got() !== expv()) begin n_fail++; $display("FAIL blink t=%0d got=%h exp=%h", t, got(), expv()); end
      if (AN[0] === 1'b0) cnt[(t - 1) / FRAME]++;
    end
    for (int f = 1; f < 6; f++) begin
      n_tests++;
      if (cnt[f] != ((f == 2 || f == 3) ? 0 : 6)) begin
        n_fail++; $display("FAIL blink_frame f=%0d on=%0d exp=%0d", f, cnt[f], (f == 2 || f == 3) ? 0 : 6);
      end
    end
    blink_mask = 4'b0000;
  endtask
`endif

  initial begin
    reset = 1; idle(); brightness = '0;
    model_reset();
    test_reset();
    test_display();
    test_brightness();
    test_shadow();
    test_wr_copy();
    test_random();
    test_reset_mid();
`ifdef SSEG_BLINK_EN
    test_blink();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
